// File: rtl/step_chunker_pkg.sv
// Shared types and helpers for the step_chunker axis command stage.
//   step_chunker_state_t : FSM state encoding
//   DIR_POS / DIR_NEG    : levels of the axis direction line
//   max_chunk()          : largest pulse count one downstream chunk can carry
package step_chunker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_FINISH
  } step_chunker_state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  function automatic int unsigned max_chunk(input int unsigned pulse_num_bits);
    return (32'd1 << pulse_num_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/step_chunker_fsm.sv
// Control FSM of step_chunker: state register plus transitions.
// Optional macro STEP_CHUNKER_DIR_SETUP_EN adds the SETUP state and its
// settle counter between command acceptance and the first chunk.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   clk_en_i        logic clock enable, gates every state update
//   cmd_valid_i     command present (only looked at in IDLE)
//   mag_zero_i      magnitude of the presented command is zero
//   rem_zero_i      no steps left after the chunk just completed
//   pg_rdy_i        downstream accepts the trigger
//   pg_done_i       downstream finished / idle
//   state_q_o       current state
//   state_d_o       state after the next clk edge
module step_chunker_fsm
  import step_chunker_pkg::*;
#(
  parameter int DIR_SETUP_TICKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en_i,
  input  logic                cmd_valid_i,
  input  logic                mag_zero_i,
  input  logic                rem_zero_i,
  input  logic                pg_rdy_i,
  input  logic                pg_done_i,
  output step_chunker_state_t state_q_o,
  output step_chunker_state_t state_d_o
);

  step_chunker_state_t state_q, state_d;

`ifdef STEP_CHUNKER_DIR_SETUP_EN
  localparam int CW = (DIR_SETUP_TICKS > 1) ? $clog2(DIR_SETUP_TICKS) : 1;
  // Loaded with TICKS-1 so SETUP lasts exactly DIR_SETUP_TICKS enabled ticks.
  localparam logic [CW-1:0] SETUP_LOAD = CW'((DIR_SETUP_TICKS > 0) ? DIR_SETUP_TICKS - 1 : 0);

  logic [CW-1:0] setup_cnt_q, setup_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) setup_cnt_q <= '0;
    else       setup_cnt_q <= setup_cnt_d;
  end
`else
  // Settle time has no meaning without the SETUP state; nothing to build.
  if (DIR_SETUP_TICKS < 0) begin : g_setup_ticks_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef STEP_CHUNKER_DIR_SETUP_EN
    setup_cnt_d = setup_cnt_q;
`endif
    if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            if (mag_zero_i) begin
              state_d = ST_FINISH;
            end else begin
`ifdef STEP_CHUNKER_DIR_SETUP_EN
              if (DIR_SETUP_TICKS > 0) state_d = ST_SETUP;
              else                     state_d = ST_ISSUE;
              setup_cnt_d = SETUP_LOAD;
`else
              state_d = ST_ISSUE;
`endif
            end
          end
        end
`ifdef STEP_CHUNKER_DIR_SETUP_EN
        ST_SETUP: begin
          if (setup_cnt_q == '0) state_d = ST_ISSUE;
          else                   setup_cnt_d = setup_cnt_q - CW'(1);
        end
`endif
        ST_ISSUE:      if (pg_rdy_i)   state_d = ST_WAIT_START;
        // A done left over from the previous chunk (or idle) must drop first.
        ST_WAIT_START: if (!pg_done_i) state_d = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (pg_done_i) begin
            if (rem_zero_i) state_d = ST_FINISH;
            else            state_d = ST_ISSUE;
          end
        end
        ST_FINISH:     state_d = ST_IDLE;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  assign state_q_o = state_q;
  assign state_d_o = state_d;

endmodule

// File: rtl/step_chunker.sv
// step_chunker: upstream command stage of an axis pulse generator.
// Takes one signed step command, sets the direction line, then feeds the
// magnitude downstream in chunks of at most 2^PULSE_NUM_BITS-1 pulses and
// pulses cmd_done once the last chunk has finished.
// Optional macro STEP_CHUNKER_DIR_SETUP_EN inserts a DIR_SETUP_TICKS settle
// period between acceptance and the first trigger.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   clk_en                logic clock enable; all updates gated by it
//   cmd_steps             signed step count, sign selects direction
//   cmd_width             pulse width forwarded to every chunk
//   cmd_valid / cmd_rdy   command handshake
//   cmd_done              one clk_en tick pulse at command completion
//   dir                   1 = positive/zero, 0 = negative
//   pg_pulse_num          chunk size presented downstream
//   pg_pulse_width        latched cmd_width
//   pg_trigger            chunk start request
//   pg_rdy / pg_done      downstream ready / finished
module step_chunker
  import step_chunker_pkg::*;
#(
  parameter int STEP_BITS        = 16,
  parameter int PULSE_NUM_BITS   = 8,
  parameter int PULSE_WIDTH_BITS = 8,
  parameter int DIR_SETUP_TICKS  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic [STEP_BITS-1:0]        cmd_steps,
  input  logic [PULSE_WIDTH_BITS-1:0] cmd_width,
  input  logic                        cmd_valid,
  output logic                        cmd_rdy,
  output logic                        cmd_done,
  output logic                        dir,
  output logic [PULSE_NUM_BITS-1:0]   pg_pulse_num,
  output logic [PULSE_WIDTH_BITS-1:0] pg_pulse_width,
  output logic                        pg_trigger,
  input  logic                        pg_rdy,
  input  logic                        pg_done
);

  localparam logic [STEP_BITS-1:0] MAX_CHUNK = STEP_BITS'(max_chunk(PULSE_NUM_BITS));

  step_chunker_state_t state_q, state_d;

  logic [STEP_BITS-1:0]        mag, chunk_src;
  logic [STEP_BITS-1:0]        rem_q, rem_d;
  logic [PULSE_NUM_BITS-1:0]   num_q, num_d, chunk_num;
  logic [PULSE_WIDTH_BITS-1:0] width_q, width_d;
  logic                        dir_q, dir_d;
  logic                        accept, enter_issue, chunk_taken;

  // Two's-complement negate read as unsigned: the most negative command
  // maps to 2^(STEP_BITS-1), which still fits in STEP_BITS bits.
  assign mag = cmd_steps[STEP_BITS-1] ? (~cmd_steps + STEP_BITS'(1)) : cmd_steps;

  assign accept      = clk_en & cmd_valid & (state_q == ST_IDLE);
  assign chunk_taken = clk_en & pg_rdy & (state_q == ST_ISSUE);
  assign enter_issue = clk_en & (state_d == ST_ISSUE) & (state_q != ST_ISSUE);

  // Entering ISSUE straight from IDLE happens before remaining is loaded,
  // so the chunk is cut from the incoming magnitude in that case.
  assign chunk_src = (state_q == ST_IDLE) ? mag : rem_q;
  assign chunk_num = (chunk_src > MAX_CHUNK) ? MAX_CHUNK[PULSE_NUM_BITS-1:0]
                                             : chunk_src[PULSE_NUM_BITS-1:0];

  step_chunker_fsm #(
    .DIR_SETUP_TICKS (DIR_SETUP_TICKS)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .clk_en_i    (clk_en),
    .cmd_valid_i (cmd_valid),
    .mag_zero_i  (mag == '0),
    .rem_zero_i  (rem_q == '0),
    .pg_rdy_i    (pg_rdy),
    .pg_done_i   (pg_done),
    .state_q_o   (state_q),
    .state_d_o   (state_d)
  );

  always_comb begin
    rem_d   = rem_q;
    num_d   = num_q;
    width_d = width_q;
    dir_d   = dir_q;
    if (accept) begin
      rem_d   = mag;
      dir_d   = ~cmd_steps[STEP_BITS-1];
      width_d = cmd_width;
    end
    if (chunk_taken) rem_d = rem_q - STEP_BITS'(num_q);
    if (enter_issue) num_d = chunk_num;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q   <= '0;
      num_q   <= '0;
      width_q <= '0;
      dir_q   <= DIR_POS;
    end else begin
      rem_q   <= rem_d;
      num_q   <= num_d;
      width_q <= width_d;
      dir_q   <= dir_d;
    end
  end

  assign cmd_rdy        = (state_q == ST_IDLE);
  assign cmd_done       = (state_q == ST_FINISH);
  assign pg_trigger     = (state_q == ST_ISSUE);
  assign dir            = dir_q;
  assign pg_pulse_num   = num_q;
  assign pg_pulse_width = width_q;

endmodule
